soc_bus_decoder: RTL

Single-master to three-slave bus decoder for AlgolSoC. It sits between the CPU data/instruction bus and the boot ROM, RAM and IO slaves, and uses the same valid/ready/error handshake as those slaves.
It decodes the request address and forwards a registered request to exactly one slave. It returns a registered response to the master.
An unmapped address, or a slave that does not answer within a bounded time, produces a bus error response.

---
 rtl/algol_bus_pkg.sv | 31 +++
 rtl/bus_addr_match.sv | 13 +
 rtl/soc_bus_decoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/algol_bus_pkg.sv
// Shared AlgolSoC bus definitions: slave indices, decoder state encoding,
// error-log cause codes and the registered request bundle.
package algol_bus_pkg;

    localparam int SLV_ROM = 0;
    localparam int SLV_RAM = 1;
    localparam int SLV_IO  = 2;
    localparam int NSLV    = 3;

    typedef logic [1:0] slv_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } bus_state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_SLVERR   = 2'b11;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  wsel;
        logic        wr;
    } bus_req_t;

endpackage

// File: rtl/bus_addr_match.sv
// Combinational region comparator: hit when the address falls inside the
// 2**AW byte window starting at BASE.
module bus_addr_match #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int          AW   = 8
) (
    input  logic [31:0] address,
    output logic        hit
);

    assign hit = (address >> AW) == (BASE >> AW);

endmodule

// File: rtl/soc_bus_decoder.sv
// Single-master to ROM/RAM/IO bus decoder with unmapped and timeout errors.
// Optional first-error log enabled by defining BUS_ERRLOG_EN.
module soc_bus_decoder
    import algol_bus_pkg::*;
#(
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
    parameter int          ROM_AW    = 8,
    parameter logic [31:0] RAM_BASE  = 32'h2000_0000,
    parameter int          RAM_AW    = 16,
    parameter logic [31:0] IO_BASE   = 32'h8000_0000,
    parameter int          IO_AW     = 12,
    parameter int          TIMEOUT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          m_address,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_wsel,
    input  logic                 m_wr,
    input  logic                 m_valid,
    output logic [31:0]          m_rdata,
    output logic                 m_ready,
    output logic                 m_error,
    output logic [31:0]          s_address,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wsel,
    output logic                 s_wr,
    output logic [NSLV-1:0]      s_valid,
    input  logic [NSLV*32-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ready,
    input  logic [NSLV-1:0]      s_error
`ifdef BUS_ERRLOG_EN
    ,
    output logic [31:0]          err_addr,
    output logic [1:0]           err_cause,
    output logic                 err_valid,
    input  logic                 err_clr
`endif
);

    localparam logic [NSLV-1:0][31:0] BASES = {IO_BASE, RAM_BASE, ROM_BASE};
    localparam int AWS [NSLV] = '{ROM_AW, RAM_AW, IO_AW};

    bus_state_t             state;
    bus_req_t               req;
    slv_idx_t               sel;
    logic [TIMEOUT_W-1:0]   cnt;
    logic [TIMEOUT_W-1:0]   cnt_nxt;
    logic                   timeout;
    logic [NSLV-1:0]        hit;
    slv_idx_t               req_sel;
    logic [NSLV-1:0]        req_oh;
    logic [NSLV-1:0][31:0]  rd_arr;
    logic [31:0]            sel_rdata;
    logic                   sel_ready;
    logic                   sel_err;

    for (genvar i = 0; i < NSLV; i++) begin : g_match
        bus_addr_match #(.BASE(BASES[i]), .AW(AWS[i])) u_match (
            .address (m_address),
            .hit     (hit[i])
        );
    end

    // Scan from the lowest-priority region up so ROM overrides RAM overrides IO.
    always_comb begin
        req_sel = slv_idx_t'(SLV_ROM);
        req_oh  = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                req_sel   = slv_idx_t'(i);
                req_oh    = '0;
                req_oh[i] = 1'b1;
            end
        end
    end

    assign rd_arr = s_rdata;

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel == slv_idx_t'(i)) begin
                sel_rdata = rd_arr[i];
                sel_ready = s_ready[i];
                sel_err   = s_error[i];
            end
        end
    end

    // Timeout fires in the cycle the count would reach all-ones.
    assign cnt_nxt = cnt + 1'b1;
    assign timeout = &cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            req     <= '0;
            sel     <= slv_idx_t'(SLV_ROM);
            cnt     <= '0;
            s_valid <= '0;
            m_ready <= 1'b0;
            m_error <= 1'b0;
            m_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (|hit) begin
                            req     <= '{address: m_address, wdata: m_wdata,
                                         wsel: m_wsel, wr: m_wr};
                            sel     <= req_sel;
                            s_valid <= req_oh;
                            cnt     <= '0;
                            state   <= ST_ACCESS;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt_nxt;
                    if (!m_valid) begin
                        s_valid <= '0;
                        state   <= ST_IDLE;
                    end else if (sel_ready) begin
                        m_rdata <= sel_rdata;
                        m_error <= sel_err;
                        m_ready <= 1'b1;
                        s_valid <= '0;
                        state   <= ST_RESP;
                    end else if (timeout) begin
                        m_rdata <= '0;
                        m_error <= 1'b1;
                        m_ready <= 1'b1;
                        s_valid <= '0;
                        state   <= ST_RESP;
                    end
                end
                ST_ERR: begin
                    m_rdata <= '0;
                    m_error <= 1'b1;
                    m_ready <= 1'b1;
                    state   <= ST_RESP;
                end
                default: begin
                    m_ready <= 1'b0;
                    m_error <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_address = req.address;
    assign s_wdata   = req.wdata;
    assign s_wsel    = req.wsel;
    assign s_wr      = req.wr;

`ifdef BUS_ERRLOG_EN
    logic        log_ev;
    logic [1:0]  log_cause;
    logic [31:0] log_addr;

    // Flag errors in the cycle their response is decided.
    always_comb begin
        log_ev    = 1'b0;
        log_cause = CAUSE_NONE;
        log_addr  = req.address;
        if (state == ST_IDLE && m_valid && !(|hit)) begin
            log_ev    = 1'b1;
            log_cause = CAUSE_UNMAPPED;
            log_addr  = m_address;
        end else if (state == ST_ACCESS && m_valid) begin
            if (sel_ready && sel_err) begin
                log_ev    = 1'b1;
                log_cause = CAUSE_SLVERR;
            end else if (!sel_ready && timeout) begin
                log_ev    = 1'b1;
                log_cause = CAUSE_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_addr  <= '0;
            err_cause <= CAUSE_NONE;
            err_valid <= 1'b0;
        end else if (log_ev && (!err_valid || err_clr)) begin
            err_addr  <= log_addr;
            err_cause <= log_cause;
            err_valid <= 1'b1;
        end else if (err_clr) begin
            err_cause <= CAUSE_NONE;
            err_valid <= 1'b0;
        end
    end
`endif

endmodule
